// File: rtl/apb_pkg.sv
// Shared APB types.
// Protection attribute type used by APB requesters and bridges.
package apb_pkg;

   typedef logic [2:0] prot_t;

endpackage

// File: rtl/axi_pkg.sv
// Shared AXI types, response codes and helpers.
// resp_is_err flags SLVERR/DECERR for APB pslverr mapping.
package axi_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   function automatic logic resp_is_err(input resp_t r);
      logic e;
      case (r)
         RESP_OKAY, RESP_EXOKAY: e = 1'b0;
         RESP_SLVERR, RESP_DECERR: e = 1'b1;
         default: e = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle.
// master drives psel/penable/pwrite/paddr/pprot/pwdata/pstrb; slave drives pready/prdata/pslverr.
interface apb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import apb_pkg::*;

   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [ADDR_WIDTH-1:0]   paddr;
   prot_t                   pprot;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/axil_if.sv
// AXI-Lite bus bundle.
// master drives aw/w/ar valid+payload and b/r ready; slave drives the rest.
interface axil_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import apb_pkg::*;
   import axi_pkg::*;

   logic                    aw_valid;
   logic                    aw_ready;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   prot_t                   aw_prot;
   logic                    w_valid;
   logic                    w_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    b_valid;
   logic                    b_ready;
   resp_t                   b_resp;
   logic                    ar_valid;
   logic                    ar_ready;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   prot_t                   ar_prot;
   logic                    r_valid;
   logic                    r_ready;
   logic [DATA_WIDTH-1:0]   r_data;
   resp_t                   r_resp;

   modport master (
      output aw_valid, aw_addr, aw_prot,
      input  aw_ready,
      output w_valid, w_data, w_strb,
      input  w_ready,
      input  b_valid, b_resp,
      output b_ready,
      output ar_valid, ar_addr, ar_prot,
      input  ar_ready,
      input  r_valid, r_data, r_resp,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_addr, aw_prot,
      output aw_ready,
      input  w_valid, w_data, w_strb,
      output w_ready,
      output b_valid, b_resp,
      input  b_ready,
      input  ar_valid, ar_addr, ar_prot,
      output ar_ready,
      output r_valid, r_data, r_resp,
      input  r_ready
   );

endinterface

// File: rtl/adam_apb_axil_bridge.sv
// APB slave to AXI-Lite master bridge, one transaction at a time, with pause.
// Ports: clk, rst (async high), test, pause_req/pause_ack, apb (slave), axil (master).
module adam_apb_axil_bridge
   import apb_pkg::*;
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   test,
   input  logic   pause_req,
   output logic   pause_ack,
   apb_if.slave   apb,
   axil_if.master axil
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [STRB_WIDTH-1:0] strb_t;

   localparam logic [2:0] S_PAUSED  = 3'd0;
   localparam logic [2:0] S_IDLE    = 3'd1;
   localparam logic [2:0] S_WR_REQ  = 3'd2;
   localparam logic [2:0] S_WR_RESP = 3'd3;
   localparam logic [2:0] S_RD_REQ  = 3'd4;
   localparam logic [2:0] S_RD_RESP = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0] state;

   addr_t addr_q;
   prot_t prot_q;
   data_t wdata_q;
   strb_t strb_q;

   logic  aw_valid_q;
   logic  w_valid_q;
   logic  b_ready_q;
   logic  ar_valid_q;
   logic  r_ready_q;
   logic  pready_q;
   data_t prdata_q;
   logic  pslverr_q;
   logic  pause_ack_q;

   // AW and W complete independently; a channel still pending
   // after this edge keeps its valid high.
   logic aw_pend;
   logic w_pend;

   assign aw_pend = aw_valid_q & ~axil.aw_ready;
   assign w_pend  = w_valid_q & ~axil.w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_PAUSED;
         addr_q      <= '0;
         prot_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         b_ready_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         pslverr_q   <= 1'b0;
         pause_ack_q <= 1'b1;
      end else begin
         case (state)
            S_PAUSED: begin
               if (!pause_req) begin
                  state       <= S_IDLE;
                  pause_ack_q <= 1'b0;
               end
            end
            S_IDLE: begin
               if (pause_req) begin
                  state       <= S_PAUSED;
                  pause_ack_q <= 1'b1;
               end else if (apb.psel) begin
                  addr_q  <= apb.paddr;
                  prot_q  <= apb.pprot;
                  wdata_q <= apb.pwdata;
                  strb_q  <= apb.pstrb;
                  if (apb.pwrite) begin
                     state      <= S_WR_REQ;
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                  end else begin
                     state      <= S_RD_REQ;
                     ar_valid_q <= 1'b1;
                  end
               end
            end
            S_WR_REQ: begin
               aw_valid_q <= aw_pend;
               w_valid_q  <= w_pend;
               if (!aw_pend && !w_pend) begin
                  state     <= S_WR_RESP;
                  b_ready_q <= 1'b1;
               end
            end
            S_WR_RESP: begin
               if (axil.b_valid) begin
                  state     <= S_DONE;
                  b_ready_q <= 1'b0;
                  pready_q  <= 1'b1;
                  prdata_q  <= '0;
                  pslverr_q <= resp_is_err(axil.b_resp);
               end
            end
            S_RD_REQ: begin
               if (axil.ar_ready) begin
                  state      <= S_RD_RESP;
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
               end
            end
            S_RD_RESP: begin
               if (axil.r_valid) begin
                  state     <= S_DONE;
                  r_ready_q <= 1'b0;
                  pready_q  <= 1'b1;
                  prdata_q  <= axil.r_data;
                  pslverr_q <= resp_is_err(axil.r_resp);
               end
            end
            S_DONE: begin
               pready_q  <= 1'b0;
               prdata_q  <= '0;
               pslverr_q <= 1'b0;
               if (pause_req) begin
                  state       <= S_PAUSED;
                  pause_ack_q <= 1'b1;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state       <= S_PAUSED;
               aw_valid_q  <= 1'b0;
               w_valid_q   <= 1'b0;
               b_ready_q   <= 1'b0;
               ar_valid_q  <= 1'b0;
               r_ready_q   <= 1'b0;
               pready_q    <= 1'b0;
               prdata_q    <= '0;
               pslverr_q   <= 1'b0;
               pause_ack_q <= 1'b1;
            end
         endcase
      end
   end

   assign pause_ack = pause_ack_q;

   assign apb.pready  = pready_q;
   assign apb.prdata  = prdata_q;
   assign apb.pslverr = pslverr_q;

   assign axil.aw_valid = aw_valid_q;
   assign axil.aw_addr  = addr_q;
   assign axil.aw_prot  = prot_q;
   assign axil.w_valid  = w_valid_q;
   assign axil.w_data   = wdata_q;
   assign axil.w_strb   = strb_q;
   assign axil.b_ready  = b_ready_q;
   assign axil.ar_valid = ar_valid_q;
   assign axil.ar_addr  = addr_q;
   assign axil.ar_prot  = prot_q;
   assign axil.r_ready  = r_ready_q;

   // penable carries no information here: setup is taken on psel alone.
   logic unused_ok;
   assign unused_ok = ^{test, apb.penable};

endmodule

// File: tb/tb_adam_apb_axil_bridge.sv
// Randomized bench for adam_apb_axil_bridge.
// Bench is APB master and AXI-Lite target; expectations come from latency/response rules.
module tb_adam_apb_axil_bridge;

   logic clk;
   logic rst;
   logic test;
   logic pause_req;
   logic pause_ack;

   apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();
   axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

   adam_apb_axil_bridge #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .test(test),
      .pause_req(pause_req),
      .pause_ack(pause_ack),
      .apb(apb),
      .axil(axil)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // target behaviour knobs
   int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
   logic [1:0]  cfg_resp;
   logic [31:0] cfg_rdata;
   bit          spur;

   logic [34:0] q_aw[$];
   logic [35:0] q_w[$];
   logic [34:0] q_ar[$];

   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   bit aw_got, w_got, ar_got, b_hs, r_hs;
   bit aw_pp, w_pp, ar_pp, spur_was;

   // AXI-Lite target: drives on negedge, DUT samples on posedge.
   always @(negedge clk) begin
      if (rst) begin
         axil.aw_ready = 0; axil.w_ready = 0; axil.ar_ready = 0;
         axil.b_valid = 0; axil.r_valid = 0;
         axil.b_resp = 0; axil.r_resp = 0; axil.r_data = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
         aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
         aw_pp = 0; w_pp = 0; ar_pp = 0; spur_was = 0;
      end else if (spur) begin
         axil.b_valid = 1; axil.r_valid = 1; spur_was = 1;
      end else begin
         if (spur_was) begin
            axil.b_valid = 0; axil.r_valid = 0; spur_was = 0;
         end
         if (aw_pp) check("aw_valid_hold", 64'(axil.aw_valid), 64'(1));
         if (w_pp) check("w_valid_hold", 64'(axil.w_valid), 64'(1));
         if (ar_pp) check("ar_valid_hold", 64'(axil.ar_valid), 64'(1));
         if (axil.aw_ready) begin
            axil.aw_ready = 0; aw_got = 1;
         end else if (axil.aw_valid) begin
            if (aw_cnt >= cfg_aw_d) begin
               axil.aw_ready = 1; aw_cnt = 0;
               q_aw.push_back({axil.aw_prot, axil.aw_addr});
            end else aw_cnt++;
         end
         if (axil.w_ready) begin
            axil.w_ready = 0; w_got = 1;
         end else if (axil.w_valid) begin
            if (w_cnt >= cfg_w_d) begin
               axil.w_ready = 1; w_cnt = 0;
               q_w.push_back({axil.w_strb, axil.w_data});
            end else w_cnt++;
         end
         if (axil.ar_ready) begin
            axil.ar_ready = 0; ar_got = 1;
         end else if (axil.ar_valid) begin
            if (ar_cnt >= cfg_ar_d) begin
               axil.ar_ready = 1; ar_cnt = 0;
               q_ar.push_back({axil.ar_prot, axil.ar_addr});
            end else ar_cnt++;
         end
         if (b_hs) begin
            axil.b_valid = 0; b_hs = 0;
         end else if (!axil.b_valid && aw_got && w_got) begin
            if (b_cnt >= cfg_b_d) begin
               axil.b_valid = 1; axil.b_resp = cfg_resp;
               aw_got = 0; w_got = 0; b_cnt = 0;
            end else b_cnt++;
         end
         if (r_hs) begin
            axil.r_valid = 0; r_hs = 0;
         end else if (!axil.r_valid && ar_got) begin
            if (r_cnt >= cfg_r_d) begin
               axil.r_valid = 1; axil.r_resp = cfg_resp;
               axil.r_data = cfg_rdata; ar_got = 0; r_cnt = 0;
            end else r_cnt++;
         end
         b_hs  = axil.b_valid && axil.b_ready;
         r_hs  = axil.r_valid && axil.r_ready;
         aw_pp = axil.aw_valid && !axil.aw_ready;
         w_pp  = axil.w_valid && !axil.w_ready;
         ar_pp = axil.ar_valid && !axil.ar_ready;
      end
   end

   task automatic apb_start(input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p);
      check("idle_valids",
            64'({axil.aw_valid, axil.w_valid, axil.ar_valid}), 64'(0));
      apb.psel = 1; apb.penable = 0; apb.pwrite = wr;
      apb.paddr = a; apb.pwdata = d; apb.pstrb = s; apb.pprot = p;
   endtask

   task automatic apb_wait(input bit drop, output int cyc,
                           output logic [31:0] rd, output logic err);
      cyc = 0; rd = '0; err = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            if (drop) apb.psel = 0;
            else apb.penable = 1;
         end
         if (apb.pready) begin
            rd = apb.prdata; err = apb.pslverr;
            check("done_axi_quiet",
                  64'({axil.aw_valid, axil.w_valid, axil.ar_valid,
                       axil.b_ready, axil.r_ready}), 64'(0));
            break;
         end
      end
      if (!apb.pready) check("pready_timeout", 64'(apb.pready), 64'(1));
   endtask

   task automatic apb_end();
      @(negedge clk);
      check("pready_pulse", 64'(apb.pready), 64'(0));
      apb.psel = 0; apb.penable = 0;
   endtask

   task automatic xfer(input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p, input logic [1:0] resp,
                       input logic [31:0] rdv, input int da,
                       input int dw, input int dr, input bit drop);
      int cyc, lat, beats;
      logic [31:0] rd;
      logic err;
      cfg_aw_d = da; cfg_w_d = dw; cfg_ar_d = da;
      cfg_b_d = dr; cfg_r_d = dr;
      cfg_resp = resp; cfg_rdata = rdv;
      q_aw.delete(); q_w.delete(); q_ar.delete();
      apb_start(wr, a, d, s, p);
      apb_wait(drop, cyc, rd, err);
      if (wr) lat = 3 + ((da > dw) ? da : dw) + dr;
      else lat = 3 + da + dr;
      check("latency", 64'(cyc), 64'(lat));
      check("prdata", 64'(rd), wr ? 64'(0) : 64'(rdv));
      check("pslverr", 64'(err), 64'(resp >= 2'd2));
      beats = q_aw.size() * 100 + q_w.size() * 10 + q_ar.size();
      check("beats", 64'(beats), wr ? 64'(110) : 64'(1));
      if (wr && q_aw.size() == 1) check("aw", 64'(q_aw[0]), 64'({p, a}));
      if (wr && q_w.size() == 1) check("w", 64'(q_w[0]), 64'({s, d}));
      if (!wr && q_ar.size() == 1) check("ar", 64'(q_ar[0]), 64'({p, a}));
      apb_end();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, gap, da, dw, dr;
      logic [31:0] rd, a, d, rdv;
      logic [3:0] s;
      logic [2:0] p;
      logic [1:0] resp;
      logic err;
      bit wr, drop, seen;

      rst = 1; test = 0; pause_req = 0; spur = 0;
      apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
      apb.paddr = 0; apb.pwdata = 0; apb.pstrb = 0; apb.pprot = 0;
      axil.aw_ready = 0; axil.w_ready = 0; axil.ar_ready = 0;
      axil.b_valid = 0; axil.r_valid = 0;
      axil.b_resp = 0; axil.r_resp = 0; axil.r_data = 0;
      cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
      cfg_resp = 0; cfg_rdata = 0;

      @(negedge clk);
      check("rst_ack", 64'(pause_ack), 64'(1));
      check("rst_outs",
            64'({apb.pready, apb.prdata, apb.pslverr, axil.aw_valid,
                 axil.w_valid, axil.ar_valid, axil.b_ready,
                 axil.r_ready}), 64'(0));
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("ack_release", 64'(pause_ack), 64'(0));

      xfer(1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 3'd0, 2'b00, 0,
           0, 0, 0, 0);
      xfer(0, 32'h0003_0004, 0, 4'hF, 3'd0, 2'b00, 32'h3,
           0, 0, 5, 0);
      xfer(1, 32'h0000_0020, 32'h1357_9BDF, 4'h3, 3'd2, 2'b00, 0,
           0, 2, 0, 0);
      xfer(1, 32'h0000_0040, 32'h2468_ACE0, 4'hF, 3'd1, 2'b10, 0,
           1, 0, 1, 0);
      xfer(0, 32'h0000_0044, 0, 4'hF, 3'd5, 2'b11, 32'h55AA_55AA,
           0, 0, 2, 0);

      // pause raised while the read waits for its response
      cfg_ar_d = 0; cfg_r_d = 5; cfg_resp = 0; cfg_rdata = 32'hA5A5_0001;
      q_aw.delete(); q_w.delete(); q_ar.delete();
      apb_start(0, 32'h0000_0100, 0, 4'hF, 3'd0);
      @(negedge clk);
      apb.penable = 1;
      @(negedge clk);
      check("rd_resp_wait", 64'(axil.r_ready), 64'(1));
      pause_req = 1;
      apb_wait(0, cyc, rd, err);
      check("pause_rd_data", 64'(rd), 64'(32'hA5A5_0001));
      check("pause_rd_err", 64'(err), 64'(0));
      apb_end();
      check("pause_ack_set", 64'(pause_ack), 64'(1));
      cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0;
      q_aw.delete(); q_w.delete(); q_ar.delete();
      apb_start(1, 32'h0000_0200, 32'h1234_5678, 4'hF, 3'd0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         apb.penable = 1;
         if (apb.pready || axil.aw_valid) seen = 1;
      end
      check("paused_stall", 64'(seen), 64'(0));
      check("pause_ack_hold", 64'(pause_ack), 64'(1));
      pause_req = 0;
      @(negedge clk);
      check("pause_ack_clr", 64'(pause_ack), 64'(0));
      apb_wait(0, cyc, rd, err);
      check("resume_lat", 64'(cyc), 64'(3));
      check("resume_err", 64'(err), 64'(0));
      check("resume_beats", 64'(q_aw.size()), 64'(1));
      if (q_w.size() == 1)
         check("resume_w", 64'(q_w[0]), 64'({4'hF, 32'h1234_5678}));
      apb_end();

      // reset while the write waits for its response
      cfg_b_d = 10; cfg_resp = 0;
      apb_start(1, 32'h0000_0300, 32'hCAFE_F00D, 4'hF, 3'd0);
      @(negedge clk);
      apb.penable = 1;
      @(negedge clk);
      check("wr_resp_wait", 64'(axil.b_ready), 64'(1));
      #2 rst = 1;
      #1;
      check("rst_async",
            64'({axil.aw_valid, axil.w_valid, axil.ar_valid,
                 axil.b_ready, axil.r_ready, apb.pready,
                 apb.pslverr}), 64'(0));
      check("rst_async_ack", 64'(pause_ack), 64'(1));
      apb.psel = 0; apb.penable = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst_recover_ack", 64'(pause_ack), 64'(0));
      xfer(1, 32'h0000_0400, 32'h0BAD_F00D, 4'hC, 3'd1, 2'b00, 0,
           0, 0, 0, 0);

      // responses with no request outstanding must not be accepted
      spur = 1;
      repeat (3) @(negedge clk);
      #1;
      check("spur_ready",
            64'({axil.b_ready, axil.r_ready, apb.pready}), 64'(0));
      spur = 0;
      repeat (2) @(negedge clk);

      for (int k = 0; k < 40; k++) begin
         wr   = 1'($urandom_range(0, 1));
         a    = $urandom;
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         p    = 3'($urandom_range(0, 7));
         resp = 2'($urandom_range(0, 3));
         rdv  = $urandom;
         da   = $urandom_range(0, 3);
         dw   = $urandom_range(0, 3);
         dr   = $urandom_range(0, 4);
         drop = ($urandom_range(0, 7) == 0);
         xfer(wr, a, d, s, p, resp, rdv, da, dw, dr, drop);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/adam_apb_axil_bridge.md
ADAM_APB_AXIL_BRIDGE -- requirements
Module: adam_apb_axil_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB/AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; STRB_WIDTH = DATA_WIDTH/8 derived.
REQ-003 SHALL have port clk  input  1  single clock; all logic in this domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port test  input  1  DFT mode; no functional effect.
REQ-006 SHALL have port pause_req  input  1  request to quiesce the bridge.
REQ-007 SHALL have port pause_ack  output  1  bridge is quiesced.
REQ-008 SHALL have port apb  APB slave modport  ADDR_WIDTH/DATA_WIDTH  upstream requester.
REQ-009 SHALL have port axil  AXI_LITE master modport  ADDR_WIDTH/DATA_WIDTH  downstream target.

Function
REQ-010 SHALL be one FSM: PAUSED, IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; all outputs registered.
REQ-011 IDLE with psel=1 (penable 0 or 1) SHALL capture paddr, pprot, pwrite, pwdata, pstrb and go to WR_REQ (pwrite=1) or RD_REQ (pwrite=0).
REQ-012 WR_REQ SHALL assert aw_valid (aw_addr=paddr, aw_prot=pprot) and w_valid (w_data=pwdata, w_strb=pstrb) together; each valid drops only after its own valid&ready cycle; both done -> WR_RESP.
REQ-013 aw and w handshakes in different cycles SHALL be tracked independently; a valid SHALL never drop before its ready.
REQ-014 WR_RESP SHALL hold b_ready=1; on b_valid&b_ready latch b_resp, go to DONE.
REQ-015 RD_REQ SHALL assert ar_valid (ar_addr=paddr, ar_prot=pprot) until ar_ready, then RD_RESP.
REQ-016 RD_RESP SHALL hold r_ready=1; on r_valid&r_ready latch r_data, r_resp, go to DONE.
REQ-017 DONE SHALL drive pready=1 for exactly one cycle with prdata=latched r_data (0 for writes) and pslverr=resp[1] (SLVERR/DECERR -> 1, OKAY/EXOKAY -> 0); next state IDLE, or PAUSED if pause_req=1.
REQ-018 pready, prdata, pslverr SHALL be 0 in every state except DONE.
REQ-019 Minimum latency with zero-wait AXI target: setup sampled cycle 0, AW/W handshake cycle 1, B cycle 2, pready cycle 3; reads identical.
REQ-020 At most one AXI transaction SHALL be outstanding; no AXI valid asserted in IDLE, PAUSED, DONE.
REQ-021 pause_req in IDLE SHALL go to PAUSED next cycle; pause_req mid-transfer SHALL be deferred until DONE completes.
REQ-022 PAUSED SHALL hold pause_ack=1 and ignore psel (APB master stalls on pready=0); pause_req=0 SHALL clear pause_ack and return to IDLE next cycle.
REQ-023 psel dropping mid-transfer (protocol violation) SHALL not abort the AXI transaction; the DONE pulse still occurs.
REQ-024 b_valid/r_valid arriving in a state not waiting for it SHALL be ignored (ready stays 0).

Reset
REQ-025 rst=1 SHALL immediately force state PAUSED, pause_ack=1, all AXI valids/readys 0, pready 0, prdata 0, pslverr 0, captured registers 0.
REQ-026 Reset mid-transfer SHALL abandon the transaction with no APB completion; no recovery attempted.

Structure
REQ-027 addr_t, data_t, strb_t SHALL derive locally from parameters; prot_t and resp codes SHALL come from shared apb_pkg/axi_pkg; the state enum stays local.
REQ-028 SHALL be a single module, no sub-module; target 150-250 lines.

Verification
REQ-029 Reset, pause_req=0: pause_ack falls within 1 cycle; APB write 0x0001_0000 data 0xDEADBEEF strb 4'b1111, zero-wait target -> aw/w match, pready pulse cycle 3, pslverr=0.
REQ-030 APB read 0x0003_0004, target returns r_data=0x3, OKAY after 5-cycle delay -> prdata=0x3 during single-cycle pready, pslverr=0.
REQ-031 Write with aw_ready 2 cycles before w_ready -> aw_valid drops after its handshake, w_valid held until w_ready, exactly one AW and one W beat.
REQ-032 Target returns b_resp=SLVERR on write and DECERR on read -> pslverr=1 on each pready pulse; prdata=0 for write.
REQ-033 pause_req raised during RD_RESP -> read completes, then PAUSED, pause_ack=1; psel held 100 ns gets no pready until pause_req=0.
REQ-034 rst asserted during WR_RESP -> all valids/readys and pready 0 without clock edge; next transfer after release completes normally.
